bank_sc: RTL and testbench

- Bank data-SRAM controller. Sits directly downstream of the bank issue unit and consumes its isu_sc request stream.
- Executes one request at a time against the two 128-bit data-SRAM halves (offset0/offset1) of a cache line.
- Fetches write data from the write buffer and returns read/evict data on a response channel.

---
 rtl/bank_sc.sv | 201 ++++++++++++++++++++
 tb/tb_bank_sc.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_sc.sv
// bank_sc: bank data-SRAM controller.
// Runs one isu_sc request at a time against the two 128-bit halves of a
// cache line: fetches write data from the write buffer, issues a single
// SRAM access, and returns read/evict data on the response channel.
//
// Handshake rule for every valid/ready pair in this block: a transfer
// happens in a cycle where valid and ready are both 1 at the rising clock
// edge; a producer holds valid and its payload stable until that transfer.
module bank_sc #(
    parameter int RD_LAT = 1,
    parameter int IDX_W  = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             isu_sc_valid_i,
    output logic             isu_sc_ready_o,
    input  logic [1:0]       isu_sc_channel_id_i,
    input  logic [2:0]       isu_sc_opcode_i,
    input  logic [6:0]       isu_sc_set_way_offset_i,
    input  logic [7:0]       isu_sc_wbuffer_id_i,
    input  logic [2:0]       isu_sc_xbar_rob_num_i,
    input  logic [1:0]       isu_sc_cacheline_dirty_offset0_i,
    input  logic [1:0]       isu_sc_cacheline_dirty_offset1_i,
    input  logic [127:0]     isu_sc_linefill_data_offset0_i,
    input  logic [127:0]     isu_sc_linefill_data_offset1_i,
    output logic             sc_wbuf_rd_valid_o,
    input  logic             sc_wbuf_rd_ready_i,
    output logic [7:0]       sc_wbuf_rd_id_o,
    input  logic [127:0]     sc_wbuf_rd_data0_i,
    input  logic [127:0]     sc_wbuf_rd_data1_i,
    output logic             sram_cen_o,
    output logic             sram_wen_o,
    output logic [1:0]       sram_wmask_o,
    output logic [IDX_W-1:0] sram_addr_o,
    output logic [127:0]     sram_wdata0_o,
    output logic [127:0]     sram_wdata1_o,
    input  logic [127:0]     sram_rdata0_i,
    input  logic [127:0]     sram_rdata1_i,
    output logic             sc_resp_valid_o,
    input  logic             sc_resp_ready_i,
    output logic [1:0]       sc_resp_channel_id_o,
    output logic [2:0]       sc_resp_rob_num_o,
    output logic             sc_resp_evict_o,
    output logic [127:0]     sc_resp_data0_o,
    output logic [127:0]     sc_resp_data1_o,
    output logic             sc_err_o,
    output logic [2:0]       sc_state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WBUF   = 3'd1,
        S_SRAM   = 3'd2,
        S_RDWAIT = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    localparam logic [2:0] OP_WRITE    = 3'd0;
    localparam logic [2:0] OP_READ     = 3'd1;
    localparam logic [2:0] OP_LINEFILL = 3'd2;
    localparam logic [2:0] OP_EVICT    = 3'd3;

    state_t           state_q, state_d;
    logic [1:0]       ch_q;
    logic [2:0]       op_q;
    logic [IDX_W-1:0] idx_q;
    logic [7:0]       wbuf_id_q;
    logic [2:0]       rob_q;
    logic [1:0]       dirty0_q, dirty1_q;
    // Shared write-data pair: loaded with linefill data at accept, and
    // overwritten by write-buffer data for WRITE requests.
    logic [127:0]     wdata0_q, wdata1_q;
    logic [127:0]     rdata0_q, rdata1_q;
    logic [2:0]       cnt_q;
    logic             err_q;
    logic             fire;
    logic             is_rd_q;
    logic             unused_offset_lsb;

    assign fire              = isu_sc_valid_i && (state_q == S_IDLE);
    assign is_rd_q           = (op_q == OP_READ) || (op_q == OP_EVICT);
    assign unused_offset_lsb = isu_sc_set_way_offset_i[0];

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (fire) begin
                    case (isu_sc_opcode_i)
                        OP_WRITE:
                            if ((isu_sc_cacheline_dirty_offset0_i != 2'd0) ||
                                (isu_sc_cacheline_dirty_offset1_i != 2'd0))
                                state_d = S_WBUF;
                        OP_READ, OP_EVICT:
                            state_d = S_SRAM;
                        OP_LINEFILL:
                            if ((isu_sc_cacheline_dirty_offset0_i == 2'd0) ||
                                (isu_sc_cacheline_dirty_offset1_i == 2'd0))
                                state_d = S_SRAM;
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_WBUF:   if (sc_wbuf_rd_ready_i) state_d = S_SRAM;
            S_SRAM:   state_d = is_rd_q ? S_RDWAIT : S_IDLE;
            S_RDWAIT: if (cnt_q == 3'd0) state_d = S_RESP;
            S_RESP:   if (sc_resp_ready_i) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Request fields, write data, read-latency counter, response data and error flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ch_q      <= '0;
            op_q      <= '0;
            idx_q     <= '0;
            wbuf_id_q <= '0;
            rob_q     <= '0;
            dirty0_q  <= '0;
            dirty1_q  <= '0;
            wdata0_q  <= '0;
            wdata1_q  <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= fire && (isu_sc_opcode_i > OP_EVICT);
            if (fire) begin
                ch_q      <= isu_sc_channel_id_i;
                op_q      <= isu_sc_opcode_i;
                idx_q     <= isu_sc_set_way_offset_i[IDX_W:1];
                wbuf_id_q <= isu_sc_wbuffer_id_i;
                rob_q     <= isu_sc_xbar_rob_num_i;
                dirty0_q  <= isu_sc_cacheline_dirty_offset0_i;
                dirty1_q  <= isu_sc_cacheline_dirty_offset1_i;
                wdata0_q  <= isu_sc_linefill_data_offset0_i;
                wdata1_q  <= isu_sc_linefill_data_offset1_i;
            end
            if ((state_q == S_WBUF) && sc_wbuf_rd_ready_i) begin
                wdata0_q <= sc_wbuf_rd_data0_i;
                wdata1_q <= sc_wbuf_rd_data1_i;
            end
            if (state_q == S_SRAM) begin
                cnt_q <= 3'(RD_LAT - 1);
            end else if (state_q == S_RDWAIT) begin
                if (cnt_q == 3'd0) begin
                    rdata0_q <= sram_rdata0_i;
                    rdata1_q <= sram_rdata1_i;
                end else begin
                    cnt_q <= cnt_q - 3'd1;
                end
            end
        end
    end

    // Outputs decoded from registered state and fields only.
    always_comb begin
        isu_sc_ready_o       = (state_q == S_IDLE);
        sc_wbuf_rd_valid_o   = (state_q == S_WBUF);
        sc_wbuf_rd_id_o      = (state_q == S_WBUF) ? wbuf_id_q : 8'd0;
        sram_cen_o           = (state_q == S_SRAM);
        sram_wen_o           = 1'b0;
        sram_wmask_o         = 2'b00;
        sram_addr_o          = '0;
        sram_wdata0_o        = '0;
        sram_wdata1_o        = '0;
        if (state_q == S_SRAM) begin
            sram_addr_o = idx_q;
            if (op_q == OP_WRITE) begin
                sram_wen_o    = 1'b1;
                sram_wmask_o  = {dirty1_q != 2'd0, dirty0_q != 2'd0};
                sram_wdata0_o = wdata0_q;
                sram_wdata1_o = wdata1_q;
            end else if (op_q == OP_LINEFILL) begin
                // Dirty halves hold newer data than the fill; never overwrite them.
                sram_wen_o    = 1'b1;
                sram_wmask_o  = {dirty1_q == 2'd0, dirty0_q == 2'd0};
                sram_wdata0_o = wdata0_q;
                sram_wdata1_o = wdata1_q;
            end
        end
        sc_resp_valid_o      = (state_q == S_RESP);
        sc_resp_channel_id_o = (state_q == S_RESP) ? ch_q : 2'd0;
        sc_resp_rob_num_o    = (state_q == S_RESP) ? rob_q : 3'd0;
        sc_resp_evict_o      = (state_q == S_RESP) && (op_q == OP_EVICT);
        sc_resp_data0_o      = (state_q == S_RESP) ? rdata0_q : 128'd0;
        sc_resp_data1_o      = (state_q == S_RESP) ? rdata1_q : 128'd0;
        sc_err_o             = err_q;
        sc_state_o           = state_q;
    end

endmodule

// File: tb/tb_bank_sc.sv
// Directed bench for bank_sc: one instance with RD_LAT=1 for the main
// sequence and one with RD_LAT=4 for latency and reset-abort cases.
module tb_bank_sc;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid, valid4;
    logic [1:0]   ch;
    logic [2:0]   op;
    logic [6:0]   off;
    logic [7:0]   wid;
    logic [2:0]   rob;
    logic [1:0]   d0, d1;
    logic [127:0] lf0, lf1;
    logic         wb_ready;
    logic [127:0] wb0, wb1;
    logic [127:0] rd0, rd1;
    logic         resp_ready;

    logic         ready, wb_valid, cen, wen, resp_valid, evict, err;
    logic [7:0]   wb_id;
    logic [1:0]   wmask, resp_ch;
    logic [5:0]   addr;
    logic [127:0] wd0, wd1, rsp0, rsp1;
    logic [2:0]   resp_rob, state;

    logic         ready_4, wb_valid_4, cen_4, wen_4, resp_valid_4, evict_4, err_4;
    logic [7:0]   wb_id_4;
    logic [1:0]   wmask_4, resp_ch_4;
    logic [5:0]   addr_4;
    logic [127:0] wd0_4, wd1_4, rsp0_4, rsp1_4;
    logic [2:0]   resp_rob_4, state_4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bank_sc #(.RD_LAT(1), .IDX_W(6)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .isu_sc_valid_i(valid), .isu_sc_ready_o(ready),
        .isu_sc_channel_id_i(ch), .isu_sc_opcode_i(op),
        .isu_sc_set_way_offset_i(off), .isu_sc_wbuffer_id_i(wid),
        .isu_sc_xbar_rob_num_i(rob),
        .isu_sc_cacheline_dirty_offset0_i(d0), .isu_sc_cacheline_dirty_offset1_i(d1),
        .isu_sc_linefill_data_offset0_i(lf0), .isu_sc_linefill_data_offset1_i(lf1),
        .sc_wbuf_rd_valid_o(wb_valid), .sc_wbuf_rd_ready_i(wb_ready),
        .sc_wbuf_rd_id_o(wb_id), .sc_wbuf_rd_data0_i(wb0), .sc_wbuf_rd_data1_i(wb1),
        .sram_cen_o(cen), .sram_wen_o(wen), .sram_wmask_o(wmask), .sram_addr_o(addr),
        .sram_wdata0_o(wd0), .sram_wdata1_o(wd1),
        .sram_rdata0_i(rd0), .sram_rdata1_i(rd1),
        .sc_resp_valid_o(resp_valid), .sc_resp_ready_i(resp_ready),
        .sc_resp_channel_id_o(resp_ch), .sc_resp_rob_num_o(resp_rob),
        .sc_resp_evict_o(evict), .sc_resp_data0_o(rsp0), .sc_resp_data1_o(rsp1),
        .sc_err_o(err), .sc_state_o(state)
    );

    bank_sc #(.RD_LAT(4), .IDX_W(6)) dut4 (
        .clk_i(clk), .rst_ni(rst_n),
        .isu_sc_valid_i(valid4), .isu_sc_ready_o(ready_4),
        .isu_sc_channel_id_i(ch), .isu_sc_opcode_i(op),
        .isu_sc_set_way_offset_i(off), .isu_sc_wbuffer_id_i(wid),
        .isu_sc_xbar_rob_num_i(rob),
        .isu_sc_cacheline_dirty_offset0_i(d0), .isu_sc_cacheline_dirty_offset1_i(d1),
        .isu_sc_linefill_data_offset0_i(lf0), .isu_sc_linefill_data_offset1_i(lf1),
        .sc_wbuf_rd_valid_o(wb_valid_4), .sc_wbuf_rd_ready_i(wb_ready),
        .sc_wbuf_rd_id_o(wb_id_4), .sc_wbuf_rd_data0_i(wb0), .sc_wbuf_rd_data1_i(wb1),
        .sram_cen_o(cen_4), .sram_wen_o(wen_4), .sram_wmask_o(wmask_4), .sram_addr_o(addr_4),
        .sram_wdata0_o(wd0_4), .sram_wdata1_o(wd1_4),
        .sram_rdata0_i(rd0), .sram_rdata1_i(rd1),
        .sc_resp_valid_o(resp_valid_4), .sc_resp_ready_i(resp_ready),
        .sc_resp_channel_id_o(resp_ch_4), .sc_resp_rob_num_o(resp_rob_4),
        .sc_resp_evict_o(evict_4), .sc_resp_data0_o(rsp0_4), .sc_resp_data1_o(rsp1_4),
        .sc_err_o(err_4), .sc_state_o(state_4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [2:0] o, input logic [6:0] f, input logic [1:0] c,
                       input logic [2:0] r, input logic [1:0] x0, input logic [1:0] x1);
        op = o; off = f; ch = c; rob = r; d0 = x0; d1 = x1;
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0; valid = 1'b0; valid4 = 1'b0;
        ch = '0; op = '0; off = '0; wid = '0; rob = '0; d0 = '0; d1 = '0;
        lf0 = '0; lf1 = '0; wb_ready = 1'b0; wb0 = '0; wb1 = '0;
        rd0 = '0; rd1 = '0; resp_ready = 1'b1;

        // Reset state
        #2;
        chk("rst_ready", ready, 1'b1);
        chk("rst_cen", cen, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_wbuf_valid", wb_valid, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_ready4", ready_4, 1'b1);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // READ offset 10 -> addr 5, RD_LAT=1
        req(3'd1, 7'd10, 2'd2, 3'd5, 2'd0, 2'd0);
        valid = 1'b1;
        chk("rd_ready_T", ready, 1'b1);
        tick();                                   // T+1
        valid = 1'b0;
        chk("rd_cen", cen, 1'b1);
        chk("rd_wen", wen, 1'b0);
        chk("rd_addr", addr, 6'd5);
        chk("rd_wmask", wmask, 2'b00);
        chk("rd_ready_busy", ready, 1'b0);
        tick();                                   // T+2: data valid
        chk("rd_cen_once", cen, 1'b0);
        chk("rd_resp_early", resp_valid, 1'b0);
        rd0 = 128'hA; rd1 = 128'hB;
        tick();                                   // T+3
        rd0 = 128'hDEAD; rd1 = 128'hBEEF;
        chk("rd_resp_valid", resp_valid, 1'b1);
        chk("rd_resp_ch", resp_ch, 2'd2);
        chk("rd_resp_rob", resp_rob, 3'd5);
        chk("rd_resp_evict", evict, 1'b0);
        chk("rd_resp_d0", rsp0, 128'hA);
        chk("rd_resp_d1", rsp1, 128'hB);
        tick();                                   // T+4
        chk("rd_ready_back", ready, 1'b1);
        chk("rd_resp_done", resp_valid, 1'b0);

        // WRITE id 3C, dirty0 only, wbuf ready after 3 cycles
        req(3'd0, 7'd20, 2'd1, 3'd1, 2'b01, 2'b00);
        wid = 8'h3C;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("wr_wbuf_valid", wb_valid, 1'b1);
            chk("wr_wbuf_id", wb_id, 8'h3C);
            chk("wr_no_cen", cen, 1'b0);
            tick();
        end
        wb_ready = 1'b1; wb0 = 128'hD0; wb1 = 128'hD1;
        chk("wr_wbuf_valid_hs", wb_valid, 1'b1);
        tick();
        wb_ready = 1'b0; wb0 = 128'h1111; wb1 = 128'h2222;
        chk("wr_cen", cen, 1'b1);
        chk("wr_wen", wen, 1'b1);
        chk("wr_wmask", wmask, 2'b01);
        chk("wr_addr", addr, 6'd10);
        chk("wr_wdata0", wd0, 128'hD0);
        chk("wr_wdata1", wd1, 128'hD1);
        chk("wr_wbuf_drop", wb_valid, 1'b0);
        tick();
        chk("wr_idle", ready, 1'b1);
        chk("wr_cen_off", cen, 1'b0);
        chk("wr_no_resp", resp_valid, 1'b0);

        // LINEFILL with only half1 dirty, offset 127 -> addr 63
        req(3'd2, 7'd127, 2'd0, 3'd0, 2'b00, 2'b10);
        lf0 = 128'h10; lf1 = 128'h11;
        valid = 1'b1;
        tick();
        valid = 1'b0; lf0 = 128'h5555; lf1 = 128'h6666;
        chk("lf_cen", cen, 1'b1);
        chk("lf_wen", wen, 1'b1);
        chk("lf_wmask", wmask, 2'b01);
        chk("lf_addr", addr, 6'd63);
        chk("lf_wdata0", wd0, 128'h10);
        chk("lf_wdata1", wd1, 128'h11);
        tick();
        chk("lf_idle", ready, 1'b1);

        // LINEFILL with both halves dirty: no SRAM access
        req(3'd2, 7'd4, 2'd0, 3'd0, 2'b01, 2'b11);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        chk("lf2_ready", ready, 1'b1);
        chk("lf2_no_cen", cen, 1'b0);

        // WRITE with both halves clean: no-op
        req(3'd0, 7'd4, 2'd0, 3'd0, 2'b00, 2'b00);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        chk("wr0_ready", ready, 1'b1);
        chk("wr0_no_wbuf", wb_valid, 1'b0);
        tick();
        chk("wr0_no_cen", cen, 1'b0);

        // EVICT with 10 cycles of response backpressure
        req(3'd3, 7'd2, 2'd1, 3'd3, 2'b00, 2'b00);
        resp_ready = 1'b0;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        chk("ev_cen", cen, 1'b1);
        chk("ev_wen", wen, 1'b0);
        chk("ev_addr", addr, 6'd1);
        tick();
        rd0 = 128'hE0; rd1 = 128'hE1;
        tick();
        rd0 = 128'h7777; rd1 = 128'h8888;
        req(3'd1, 7'd4, 2'd3, 3'd7, 2'b00, 2'b00);
        valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("ev_resp_valid", resp_valid, 1'b1);
            chk("ev_resp_evict", evict, 1'b1);
            chk("ev_resp_d0", rsp0, 128'hE0);
            chk("ev_resp_d1", rsp1, 128'hE1);
            chk("ev_resp_rob", resp_rob, 3'd3);
            chk("ev_not_ready", ready, 1'b0);
            tick();
        end
        resp_ready = 1'b1;
        chk("ev_resp_hs", resp_valid, 1'b1);
        chk("ev_resp_ch", resp_ch, 2'd1);
        tick();
        chk("ev_ready_back", ready, 1'b1);
        chk("ev_resp_gone", resp_valid, 1'b0);
        tick();
        valid = 1'b0;
        chk("pend_cen", cen, 1'b1);
        chk("pend_addr", addr, 6'd2);
        tick();
        rd0 = 128'hC0; rd1 = 128'hC1;
        tick();
        chk("pend_resp_valid", resp_valid, 1'b1);
        chk("pend_resp_rob", resp_rob, 3'd7);
        chk("pend_resp_ch", resp_ch, 2'd3);
        chk("pend_resp_evict", evict, 1'b0);
        chk("pend_resp_d0", rsp0, 128'hC0);
        tick();
        chk("pend_idle", ready, 1'b1);

        // Illegal opcode 6: one-cycle error pulse, no activity
        req(3'd6, 7'd8, 2'd0, 3'd0, 2'b01, 2'b01);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        chk("ill_err", err, 1'b1);
        chk("ill_ready", ready, 1'b1);
        chk("ill_no_cen", cen, 1'b0);
        chk("ill_no_wbuf", wb_valid, 1'b0);
        tick();
        chk("ill_err_once", err, 1'b0);
        chk("ill_no_cen2", cen, 1'b0);

        // RD_LAT=4: READ latency (resp at T+6)
        req(3'd1, 7'd12, 2'd2, 3'd4, 2'b00, 2'b00);
        valid4 = 1'b1;
        tick();                                   // T+1
        valid4 = 1'b0;
        chk("l4_cen", cen_4, 1'b1);
        chk("l4_addr", addr_4, 6'd6);
        tick(); tick(); tick();                   // T+4
        chk("l4_resp_early", resp_valid_4, 1'b0);
        tick();                                   // T+5: data valid
        rd0 = 128'h44; rd1 = 128'h45;
        chk("l4_resp_t5", resp_valid_4, 1'b0);
        tick();                                   // T+6
        rd0 = 128'h0; rd1 = 128'h0;
        chk("l4_resp_valid", resp_valid_4, 1'b1);
        chk("l4_resp_d0", rsp0_4, 128'h44);
        chk("l4_resp_d1", rsp1_4, 128'h45);
        tick();                                   // T+7
        chk("l4_ready_back", ready_4, 1'b1);

        // RD_LAT=4: reset asserted in RDWAIT drops the request
        req(3'd1, 7'd8, 2'd1, 3'd2, 2'b00, 2'b00);
        valid4 = 1'b1;
        tick();
        valid4 = 1'b0;
        tick(); tick();
        chk("ra_busy", ready_4, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("ra_ready", ready_4, 1'b1);
        chk("ra_cen", cen_4, 1'b0);
        chk("ra_resp_valid", resp_valid_4, 1'b0);
        chk("ra_resp_rob", resp_rob_4, 3'd0);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (resp_valid_4) seen = 1'b1;
        end
        chk("ra_no_resp", seen, 1'b0);
        chk("ra_ready_after", ready_4, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
